alu_result_buffer: RTL

Fixed-depth in-order result FIFO between the combinational ALU and the integer writeback port of the issue/commit logic. It captures each ALU result together with its transaction ID and presents it with a valid/ready handshake to writeback. Writeback can stall, and the buffer exerts backpressure on ALU issue through alu_ready_o. It also discards in-flight results on a pipeline flush.

---
 rtl/alu_result_buffer.sv | 110 +++++++++++
 1 files changed

// File: rtl/alu_result_buffer.sv
// In-order result FIFO between the ALU and the integer writeback port.
// Registered-only ready/valid so writeback stalls never reach ALU issue combinationally.
module alu_result_buffer #(
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3,
    parameter int DEPTH         = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     alu_valid_i,
    input  logic [TRANS_ID_BITS-1:0] alu_trans_id_i,
    input  logic [XLEN-1:0]          alu_result_i,
    output logic                     alu_ready_o,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]          wb_result_o,
    input  logic                     wb_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [TRANS_ID_BITS-1:0] id_mem_q  [DEPTH];
    logic [XLEN-1:0]          res_mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;
    logic empty;

    assign empty       = (count_q == '0);
    assign alu_ready_o = (count_q < DEPTH_C);
    assign wb_valid_o  = !empty;
    assign count_o     = count_q;

    // A flush cycle drops both sides of the handshake, not just the stored entries.
    assign push = alu_valid_i && alu_ready_o && !flush_i;
    assign pop  = wb_valid_o && wb_ready_i && !flush_i;

    always_comb begin
        wb_trans_id_o = '0;
        wb_result_o   = '0;
        if (!empty) begin
            wb_trans_id_o = id_mem_q[rd_ptr_q];
            wb_result_o   = res_mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; empty entries are masked at the outputs instead.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem_q[wr_ptr_q]  <= alu_trans_id_i;
            res_mem_q[wr_ptr_q] <= alu_result_i;
        end
    end

`ifndef SYNTHESIS
    localparam bit DEPTH_OK = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0);

    a_depth_pow2: assert property (@(posedge clk_i) DEPTH_OK);

    a_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= DEPTH_C);

    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        pop |-> (count_q != '0));

    a_stall_stable: assert property (@(posedge clk_i)
        (!rst_i && !flush_i && wb_valid_o && !wb_ready_i)
        |=> ($stable(wb_trans_id_o) && $stable(wb_result_o) && wb_valid_o));
`endif

endmodule
